// File: rtl/servant_bootloader.sv
// Boot loader: packs an incoming byte stream into little-endian 32-bit words and
// writes them to RAM over Wishbone while holding the CPU in reset, then releases it.
module servant_bootloader #(
    parameter int memsize = 8192,
    parameter int aw      = $clog2(memsize)
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_done,
    output logic [aw-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_overflow
);

    // S_RECOV is the idle cycle after an ack; it decides between LOAD and RUN.
    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RECOV, S_RUN} state_t;

    localparam logic [aw-1:0] LAST_ADR = aw'(memsize - 4);
    localparam logic [aw-1:0] WORD_INC = aw'(4);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          cyc_q, cyc_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          ovf_q, ovf_d;
    logic          pend_q, pend_d;
    logic          full_q, full_d;

    logic xfer;
    logic keep;
    logic has_bytes;

    assign xfer      = i_valid && (state_q == S_LOAD);
    // Once the last RAM word has been written, accepted bytes are discarded.
    assign keep      = xfer && !full_q;
    assign has_bytes = keep || (idx_q != 2'd0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        cpu_rst_d = cpu_rst_q;
        ovf_d     = ovf_q;
        pend_d    = pend_q;
        full_d    = full_q;

        case (state_q)
            S_LOAD: begin
                if (xfer && full_q) begin
                    ovf_d = 1'b1;
                end
                if (keep) begin
                    dat_d[{idx_q, 3'b000} +: 8] = i_data;
                    sel_d[idx_q]                = 1'b1;
                    idx_d                       = idx_q + 2'd1;
                end
                // A done strobe with a partial word flushes it before RUN.
                if ((keep && (idx_q == 2'd3)) || (i_done && has_bytes)) begin
                    state_d = S_WRITE;
                    cyc_d   = 1'b1;
                    pend_d  = i_done;
                end else if (i_done) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                end
            end

            S_WRITE: begin
                if (i_done) begin
                    pend_d = 1'b1;
                end
                if (i_wb_ack) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'd0;
                    dat_d   = 32'd0;
                    idx_d   = 2'd0;
                    state_d = S_RECOV;
                    if (adr_q == LAST_ADR) begin
                        full_d = 1'b1;
                    end else begin
                        adr_d = adr_q + WORD_INC;
                    end
                end
            end

            S_RECOV: begin
                if (pend_q || i_done) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                end else begin
                    state_d = S_LOAD;
                end
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= S_LOAD;
            idx_q     <= 2'd0;
            adr_q     <= '0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            cyc_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            cpu_rst_q <= cpu_rst_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
        end
    end

    assign o_ready    = (state_q == S_LOAD);
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_we    = cyc_q;
    assign o_wb_cyc   = cyc_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_servant_bootloader.sv
// Bench for servant_bootloader: two instances (8 KiB and 8-byte RAM) share one byte
// stream; bus writes are logged and compared with a word-packing reference model.
module tb_servant_bootloader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_rst, i_valid, i_done;
    logic [7:0]  i_data;

    logic        ready0, ready8;
    logic [12:0] adr0;
    logic [2:0]  adr8;
    logic [31:0] dat0, dat8;
    logic [3:0]  sel0, sel8;
    logic        we0, we8, cyc0, cyc8, crst0, crst8, ovf0, ovf8;
    logic        ack0 = 1'b0;
    logic        ack8 = 1'b0;

    servant_bootloader #(.memsize(8192)) dut (
        .wb_clk(clk), .wb_rst(wb_rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready0), .i_done(i_done), .o_wb_adr(adr0), .o_wb_dat(dat0),
        .o_wb_sel(sel0), .o_wb_we(we0), .o_wb_cyc(cyc0), .i_wb_ack(ack0),
        .o_cpu_rst(crst0), .o_overflow(ovf0)
    );

    servant_bootloader #(.memsize(8)) dut8 (
        .wb_clk(clk), .wb_rst(wb_rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready8), .i_done(i_done), .o_wb_adr(adr8), .o_wb_dat(dat8),
        .o_wb_sel(sel8), .o_wb_we(we8), .o_wb_cyc(cyc8), .i_wb_ack(ack8),
        .o_cpu_rst(crst8), .o_overflow(ovf8)
    );

    // RAM responders: ack arrives ack_dly+1 cycles after cyc rises, one cycle wide.
    int ack_dly = 0;
    int cnt0 = 0;
    int cnt8 = 0;
    always @(posedge clk) begin
        ack0 <= 1'b0;
        ack8 <= 1'b0;
        if (cyc0 === 1'b1 && !ack0) begin
            if (cnt0 >= ack_dly) begin ack0 <= 1'b1; cnt0 <= 0; end
            else cnt0 <= cnt0 + 1;
        end else cnt0 <= 0;
        if (cyc8 === 1'b1 && !ack8) begin
            if (cnt8 >= ack_dly) begin ack8 <= 1'b1; cnt8 <= 0; end
            else cnt8 <= cnt8 + 1;
        end else cnt8 <= 0;
    end

    logic [51:0] wlog [2][256];
    int wn [2] = '{0, 0};
    int cyc_hi0 = 0, rise0 = 0, rise8 = 0, rdy_bad0 = 0;
    logic prev0 = 1'b0, prev8 = 1'b0;
    always @(negedge clk) begin
        if (cyc0 === 1'b1 && ack0 && wn[0] < 256) begin
            wlog[0][wn[0]] <= {16'(adr0), dat0, sel0};
            wn[0] <= wn[0] + 1;
        end
        if (cyc8 === 1'b1 && ack8 && wn[1] < 256) begin
            wlog[1][wn[1]] <= {16'(adr8), dat8, sel8};
            wn[1] <= wn[1] + 1;
        end
        if (cyc0 === 1'b1) cyc_hi0 <= cyc_hi0 + 1;
        if (cyc0 === 1'b1 && !prev0) rise0 <= rise0 + 1;
        if (cyc8 === 1'b1 && !prev8) rise8 <= rise8 + 1;
        if (cyc0 === 1'b1 && ready0 === 1'b1) rdy_bad0 <= rdy_bad0 + 1;
        prev0 <= (cyc0 === 1'b1);
        prev8 <= (cyc8 === 1'b1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_rst = 1'b1; i_valid = 1'b0; i_done = 1'b0; i_data = 8'd0;
        tick(2);
        wb_rst = 1'b0;
        tick(2);
    endtask

    // Offers one byte until the 8 KiB instance takes it; optional done in the same cycle.
    task automatic send(input logic [7:0] b, input logic with_done);
        int n;
        n = 0;
        i_data = b;
        i_valid = 1'b1;
        while (ready0 !== 1'b1 && n < 200) begin tick(1); n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $error("FAIL send_timeout: observed %0d cycles waiting expected fewer than 200", n);
        end
        i_done = with_done;
        tick(1);
        i_valid = 1'b0;
        i_done = 1'b0;
    endtask

    task automatic pulse_done();
        i_done = 1'b1;
        tick(1);
        i_done = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (crst0 !== 1'b0 && n < 300) begin tick(1); n++; end
        chk(tag, crst0, 1'b0);
    endtask

    // Reference: bytes fill words in order, little-endian, last word partial; words beyond RAM are lost.
    task automatic check_writes(input int d, input int base, input logic [7:0] bq[$],
                                input int msize, input string tag);
        int nbytes, nw;
        logic [31:0] w;
        logic [3:0] s;
        nbytes = bq.size();
        nw = (nbytes + 3) / 4;
        if (nw > msize / 4) nw = msize / 4;
        chk({tag, "_count"}, wn[d] - base, nw);
        for (int k = 0; k < nw; k++) begin
            w = 32'd0;
            s = 4'd0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < nbytes) begin
                    w[8 * j +: 8] = bq[4 * k + j];
                    s[j] = 1'b1;
                end
            end
            chk($sformatf("%s_w%0d", tag, k), wlog[d][base + k], {16'(4 * k), w, s});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        int b0, b8, h0, rb, r0, r8, n, gap;
        logic comb;

        wb_rst = 1'b1; i_valid = 1'b0; i_done = 1'b0; i_data = 8'd0;
        do_reset();
        chk("rst_cyc", cyc0, 1'b0);
        chk("rst_we", we0, 1'b0);
        chk("rst_sel", sel0, 4'd0);
        chk("rst_dat", dat0, 32'd0);
        chk("rst_adr", adr0, 13'd0);
        chk("rst_cpu_rst", crst0, 1'b1);
        chk("rst_ovf", ovf0, 1'b0);
        chk("rst_ready", ready0, 1'b1);

        // One full word, back-to-back, ack in the second cyc cycle
        b0 = wn[0]; h0 = cyc_hi0; rb = rdy_bad0;
        ack_dly = 0;
        send(8'h78, 1'b0); send(8'h56, 1'b0); send(8'h34, 1'b0); send(8'h12, 1'b0);
        tick(4);
        chk("t1_nw", wn[0] - b0, 1);
        chk("t1_word", wlog[0][b0], {16'h0, 32'h12345678, 4'hF});
        chk("t1_cyc_len", cyc_hi0 - h0, 2);
        chk("t1_ready_in_write", rdy_bad0 - rb, 0);
        chk("t1_cpu_rst", crst0, 1'b1);

        // Eight bytes with gaps, then done at a word boundary
        do_reset();
        b0 = wn[0]; b8 = wn[1];
        bq.delete();
        for (int i = 0; i < 8; i++) begin
            bq.push_back(8'($urandom));
            tick($urandom_range(0, 3));
            send(bq[i], 1'b0);
        end
        n = 0;
        while (ready0 !== 1'b1 && n < 100) begin tick(1); n++; end
        chk("t2_back_to_load", ready0, 1'b1);
        chk("t2_rst_before", crst0, 1'b1);
        pulse_done();
        chk("t2_rst_after", crst0, 1'b0);
        chk("t2_m8_rst_after", crst8, 1'b0);
        tick(2);
        check_writes(0, b0, bq, 8192, "t2");
        check_writes(1, b8, bq, 8, "t2m8");

        // Partial word flush
        do_reset();
        b0 = wn[0];
        bq.delete(); bq.push_back(8'hAA); bq.push_back(8'hBB);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        pulse_done();
        wait_run("t3_run");
        tick(2);
        chk("t3_word", wlog[0][b0], {16'h0, 32'h0000BBAA, 4'b0011});
        check_writes(0, b0, bq, 8192, "t3");
        chk("t3_ready_run", ready0, 1'b0);
        chk("t3_cyc_run", cyc0, 1'b0);

        // Done during a slow write
        do_reset();
        b0 = wn[0]; r0 = rise0;
        ack_dly = 5;
        bq.delete();
        for (int i = 0; i < 4; i++) begin
            bq.push_back(8'($urandom));
            send(bq[i], 1'b0);
        end
        chk("t4_in_write", cyc0, 1'b1);
        pulse_done();
        n = 0;
        while (ack0 !== 1'b1 && n < 50) begin tick(1); n++; end
        chk("t4_ack_seen", ack0, 1'b1);
        tick(1);
        chk("t4_recov_ready", ready0, 1'b0);
        chk("t4_recov_rst", crst0, 1'b1);
        tick(1);
        chk("t4_run_rst", crst0, 1'b0);
        chk("t4_run_ready", ready0, 1'b0);
        tick(3);
        check_writes(0, b0, bq, 8192, "t4");
        chk("t4_one_cyc", rise0 - r0, 1);

        // Overflow on the 8-byte instance
        do_reset();
        ack_dly = 0;
        b0 = wn[0]; b8 = wn[1]; r8 = rise8;
        bq.delete();
        for (int i = 0; i < 12; i++) begin
            bq.push_back(8'($urandom));
            if (i == 8) chk("t5_ovf_before", ovf8, 1'b0);
            send(bq[i], 1'b0);
            if (i == 8) chk("t5_ovf_after9", ovf8, 1'b1);
        end
        tick(6);
        check_writes(0, b0, bq, 8192, "t5");
        check_writes(1, b8, bq, 8, "t5m8");
        chk("t5_m8_two_cyc", rise8 - r8, 2);
        chk("t5_ovf_sticky", ovf8, 1'b1);
        chk("t5_big_no_ovf", ovf0, 1'b0);

        // Reset in the middle of a write
        do_reset();
        ack_dly = 0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        tick(3);
        ack_dly = 10;
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        tick(2);
        chk("t6_mid_cyc", cyc0, 1'b1);
        chk("t6_mid_adr", adr0, 13'h4);
        wb_rst = 1'b1;
        tick(1);
        chk("t6_rst_cyc", cyc0, 1'b0);
        chk("t6_rst_cpu", crst0, 1'b1);
        chk("t6_rst_adr", adr0, 13'h0);
        wb_rst = 1'b0;
        ack_dly = 0;
        tick(2);
        b0 = wn[0];
        bq.delete();
        for (int i = 0; i < 4; i++) begin
            bq.push_back(8'($urandom));
            send(bq[i], 1'b0);
        end
        tick(4);
        check_writes(0, b0, bq, 8192, "t6");

        // Randomised images against the packing model
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ack_dly = $urandom_range(0, 3);
            b0 = wn[0]; b8 = wn[1];
            n = $urandom_range(1, 14);
            comb = 1'($urandom_range(0, 1));
            bq.delete();
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                gap = $urandom_range(0, 3);
                tick(gap);
                send(bq[i], (i == n - 1) && comb);
            end
            if (!comb) begin
                tick($urandom_range(0, 3));
                pulse_done();
            end
            wait_run($sformatf("rnd%0d_run", t));
            tick(3);
            check_writes(0, b0, bq, 8192, $sformatf("rnd%0d", t));
            check_writes(1, b8, bq, 8, $sformatf("rnd%0dm8", t));
            chk($sformatf("rnd%0d_m8_ovf", t), ovf8, (n > 8) ? 1'b1 : 1'b0);
            chk($sformatf("rnd%0d_m8_run", t), crst8, 1'b0);
            chk($sformatf("rnd%0d_ovf", t), ovf0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
